quadrature_decoder: RTL and testbench
=====================================

QUADRATURE_DECODER -- requirements
Module: quadrature_decoder

Interface
REQ-001 Parameter COUNT_BIT_WIDTH, default 8: width of the position count.
REQ-002 Parameter FILTER_CYCLES, default 3, legal range 1..15: cycles an input must hold a new level before it is accepted.
REQ-003 Port Clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port ResetN  input  1  asynchronous, active-low reset.
REQ-005 Port EncA, EncB  input  1 each  raw quadrature channels, asynchronous to Clk.
REQ-006 Port Enable  input  1  1 = steps update Count and pulse StepValid.
REQ-007 Port ClearCount  input  1  synchronous clear of Count.
REQ-008 Port ErrorClear  input  1  synchronous clear of Error.
REQ-009 Port Count  output  COUNT_BIT_WIDTH  saturating position count.
REQ-010 Port Direction  output  1  last accepted step: 1 = up, 0 = down.
REQ-011 Port StepValid  output  1  one-cycle pulse per accepted step.
REQ-012 Port Error  output  1  sticky flag for an illegal transition.

Function
REQ-013 Each channel SHALL pass through a 2-flop synchronizer and then a glitch filter: the filtered level changes only after the synchronized level has differed from it for FILTER_CYCLES consecutive cycles; any return to the old level restarts the run.
REQ-014 The decoded state is {A,B}. Up sequence: 00->01->11->10->00. Down sequence: the reverse.
REQ-015 An unchanged filtered state SHALL cause no action.
REQ-016 A legal up or down step SHALL update Direction, pulse StepValid for exactly one cycle when Enable=1, and increment or decrement Count when Enable=1.
REQ-017 Latency SHALL be exactly 2+FILTER_CYCLES cycles, from the first Clk edge that samples the new pin level to StepValid high.
REQ-018 Count SHALL saturate: an up step at 2^COUNT_BIT_WIDTH-1 or a down step at 0 leaves Count unchanged. StepValid and Direction still update.
REQ-019 A change of both bits in one filtered update (00<->11, 01<->10) SHALL set Error. Count, Direction and StepValid are unaffected. The new state becomes the reference.
REQ-020 With Enable=0, state tracking and Error detection SHALL continue. Count holds and StepValid stays 0.
REQ-021 ClearCount SHALL force Count to 0 and takes priority over a same-cycle step. Direction and StepValid still reflect that step.
REQ-022 ErrorClear SHALL clear Error, except that a same-cycle new illegal transition leaves Error at 1.
REQ-023 Prime rule: after reset, the first filtered state accepted on each channel SHALL be loaded as the reference state, with no step and no Error.

Reset
REQ-024 ResetN low SHALL immediately, without a clock edge, force the following to 0: Count, Direction, StepValid, Error, the synchronizers, the filter run counters and the primed flag.
REQ-025 Deassertion of ResetN SHALL take effect at the next Clk edge. Reset asserted mid-sequence SHALL discard partially filtered levels.

Structure
REQ-026 Package quadrature_pkg SHALL hold the 2-bit state encodings (S00, S01, S11, S10) and the step-classification constants (NONE, UP, DOWN, ILLEGAL).
REQ-027 The synchronizer and glitch filter SHALL be one sub-module, sync_glitch_filter (parameter FILTER_CYCLES), instantiated once per channel. The transition classifier and the count logic stay in the top level.

Verification (COUNT_BIT_WIDTH=8, FILTER_CYCLES=3)
REQ-028 Prime at 00, then 01, 11, 10, 00, each held 10 cycles -> Count=4, Direction=1, four StepValid pulses, each 5 cycles after its pin change.
REQ-029 Count=0, then a down step 00->10 -> Count stays 0, Direction=0, one StepValid pulse.
REQ-030 Glitch: EncA high for 2 cycles, then low -> no StepValid, Count unchanged, Error=0.
REQ-031 Filtered 00->11 -> Error=1 and Count unchanged. Then ErrorClear pulse -> Error=0. Then ErrorClear in the same cycle as a new 01->10 -> Error=1.
REQ-032 Count=255 plus an up step -> Count stays 255. Then ClearCount in the same cycle as an up step -> Count=0, StepValid=1.
REQ-033 ResetN low mid-run with no Clk edge -> all outputs 0 at once. Release with pins at 11 -> primes at 11 with no StepValid and no Error. A following 11->10 step gives Count=1.

Source files
------------

// File: rtl/quadrature_pkg.sv
// Shared encodings and the step classifier for the quadrature decoder.
// States are Gray-coded {A,B}; converting to binary turns a step into a mod-4 delta.
package quadrature_pkg;

  typedef enum logic [1:0] {
    S00 = 2'b00,
    S01 = 2'b01,
    S11 = 2'b11,
    S10 = 2'b10
  } qstate_t;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    UP      = 2'd1,
    DOWN    = 2'd2,
    ILLEGAL = 2'd3
  } step_t;

  localparam int NUM_CH = 2;
  localparam int CNT_W  = 4;

  // Position along the up sequence 00,01,11,10.
  function automatic logic [1:0] gray_idx(input qstate_t s);
    return {s[1], s[1] ^ s[0]};
  endfunction

  function automatic step_t classify(input qstate_t prev, input qstate_t cur);
    logic [1:0] d;
    d = gray_idx(cur) - gray_idx(prev);
    case (d)
      2'd0:    return NONE;
      2'd1:    return UP;
      2'd2:    return ILLEGAL;
      default: return DOWN;
    endcase
  endfunction

endpackage

// File: rtl/sync_glitch_filter.sv
// Two-flop synchronizer followed by a run-length glitch filter for one channel.
// Valid rises once a first stable level has been seen after reset.
module sync_glitch_filter
  import quadrature_pkg::*;
#(
  parameter int FILTER_CYCLES = 3
) (
  input  logic Clk,
  input  logic ResetN,
  input  logic Din,
  output logic Level,
  output logic Valid
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FILTER_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] run;

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      sync  <= '0;
      run   <= '0;
      Level <= 1'b0;
      Valid <= 1'b0;
    end else begin
      sync <= {sync[0], Din};
      if (!Valid) begin
        // Before priming, Level tracks the candidate and the run measures its stability.
        if (sync[1] != Level) begin
          Level <= sync[1];
          run   <= '0;
        end else if (run == LAST) begin
          Valid <= 1'b1;
          run   <= '0;
        end else begin
          run <= run + 1'b1;
        end
      end else if (sync[1] != Level) begin
        if (run == LAST) begin
          Level <= sync[1];
          run   <= '0;
        end else begin
          run <= run + 1'b1;
        end
      end else begin
        run <= '0;
      end
    end
  end

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature decoder: filtered A/B channels feed a step classifier and a
// saturating position counter with sticky illegal-transition flag.
module quadrature_decoder
  import quadrature_pkg::*;
#(
  parameter int COUNT_BIT_WIDTH = 8,
  parameter int FILTER_CYCLES   = 3
) (
  input  logic                       Clk,
  input  logic                       ResetN,
  input  logic                       EncA,
  input  logic                       EncB,
  input  logic                       Enable,
  input  logic                       ClearCount,
  input  logic                       ErrorClear,
  output logic [COUNT_BIT_WIDTH-1:0] Count,
  output logic                       Direction,
  output logic                       StepValid,
  output logic                       Error
);

  localparam logic [COUNT_BIT_WIDTH-1:0] CMAX = '1;

  logic [NUM_CH-1:0] enc, lvl, vld;
  qstate_t           cur, ref_st;
  step_t             cls;
  logic              primed;

  assign enc = {EncA, EncB};

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    sync_glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt (
      .Clk   (Clk),
      .ResetN(ResetN),
      .Din   (enc[ch]),
      .Level (lvl[ch]),
      .Valid (vld[ch])
    );
  end

  assign cur = qstate_t'(lvl);
  assign cls = classify(ref_st, cur);

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      Count     <= '0;
      Direction <= 1'b0;
      StepValid <= 1'b0;
      Error     <= 1'b0;
      primed    <= 1'b0;
      ref_st    <= S00;
    end else begin
      StepValid <= 1'b0;
      if (ErrorClear) Error <= 1'b0;
      if (!primed) begin
        // Both channels must have a settled level before it becomes the reference.
        if (&vld) begin
          primed <= 1'b1;
          ref_st <= cur;
        end
      end else begin
        ref_st <= cur;
        case (cls)
          UP: begin
            Direction <= 1'b1;
            if (Enable) begin
              StepValid <= 1'b1;
              if (Count != CMAX) Count <= Count + 1'b1;
            end
          end
          DOWN: begin
            Direction <= 1'b0;
            if (Enable) begin
              StepValid <= 1'b1;
              if (Count != '0) Count <= Count - 1'b1;
            end
          end
          ILLEGAL: Error <= 1'b1;
          default: ;
        endcase
      end
      if (ClearCount) Count <= '0;
    end
  end

endmodule

// File: tb/tb_quadrature_decoder.sv
// Directed bench for quadrature_decoder (COUNT_BIT_WIDTH=8, FILTER_CYCLES=3).
module tb_quadrature_decoder;

  logic       Clk = 1'b0;
  logic       ResetN = 1'b0;
  logic       EncA = 1'b0, EncB = 1'b0;
  logic       Enable = 1'b1, ClearCount = 1'b0, ErrorClear = 1'b0;
  logic [7:0] Count;
  logic       Direction, StepValid, Error;

  int         checks = 0, errors = 0;
  int         p, l;
  logic [1:0] st;

  quadrature_decoder #(.COUNT_BIT_WIDTH(8), .FILTER_CYCLES(3)) dut (
    .Clk       (Clk),
    .ResetN    (ResetN),
    .EncA      (EncA),
    .EncB      (EncB),
    .Enable    (Enable),
    .ClearCount(ClearCount),
    .ErrorClear(ErrorClear),
    .Count     (Count),
    .Direction (Direction),
    .StepValid (StepValid),
    .Error     (Error)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive pins at a falling edge, then watch hold cycles for StepValid pulses.
  task automatic apply(input logic a, input logic b, input int hold,
                       output int pulses, output int lat);
    EncA = a; EncB = b; pulses = 0; lat = -1;
    for (int i = 1; i <= hold; i++) begin
      @(negedge Clk);
      if (StepValid === 1'b1) begin
        pulses++;
        if (lat < 0) lat = i - 1;
      end
    end
  endtask

  function automatic logic [1:0] up_of(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] down_of(input logic [1:0] s);
    case (s)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  initial begin
    #2;
    chk("rst_count", Count, 0);
    chk("rst_dir", Direction, 0);
    chk("rst_sv", StepValid, 0);
    chk("rst_err", Error, 0);
    @(negedge Clk); ResetN = 1'b1;

    apply(0, 0, 10, p, l); chk("prime00_pulses", p, 0);

    apply(0, 1, 10, p, l); chk("up1_pulses", p, 1); chk("up1_lat", l, 5);
    apply(1, 1, 10, p, l); chk("up2_pulses", p, 1); chk("up2_lat", l, 5);
    apply(1, 0, 10, p, l); chk("up3_pulses", p, 1); chk("up3_lat", l, 5);
    apply(0, 0, 10, p, l); chk("up4_pulses", p, 1); chk("up4_lat", l, 5);
    chk("up_count", Count, 4);
    chk("up_dir", Direction, 1);

    ClearCount = 1'b1; @(negedge Clk); ClearCount = 1'b0;
    chk("clr_count", Count, 0);
    apply(1, 0, 10, p, l);
    chk("down0_pulses", p, 1); chk("down0_count", Count, 0); chk("down0_dir", Direction, 0);
    apply(0, 0, 10, p, l);
    chk("back00_count", Count, 1); chk("back00_dir", Direction, 1);

    EncA = 1'b1; p = 0;
    repeat (2) begin @(negedge Clk); if (StepValid === 1'b1) p++; end
    EncA = 1'b0;
    repeat (10) begin @(negedge Clk); if (StepValid === 1'b1) p++; end
    chk("glitch_pulses", p, 0); chk("glitch_count", Count, 1); chk("glitch_err", Error, 0);

    apply(1, 1, 10, p, l);
    chk("ill_pulses", p, 0); chk("ill_err", Error, 1);
    chk("ill_count", Count, 1); chk("ill_dir", Direction, 1);
    ErrorClear = 1'b1; @(negedge Clk); ErrorClear = 1'b0;
    chk("errclr", Error, 0);
    apply(0, 1, 10, p, l);
    chk("down11_01_count", Count, 0);

    // Illegal 01->10 lands on the 6th rising edge; raise ErrorClear for exactly that edge.
    EncA = 1'b1; EncB = 1'b0;
    repeat (5) @(negedge Clk);
    ErrorClear = 1'b1; @(negedge Clk); ErrorClear = 1'b0;
    chk("errclr_vs_ill", Error, 1);
    repeat (5) @(negedge Clk);
    ErrorClear = 1'b1; @(negedge Clk); ErrorClear = 1'b0;
    chk("errclr2", Error, 0);

    st = 2'b10;
    for (int k = 0; k < 255; k++) begin
      st = up_of(st);
      apply(st[1], st[0], 8, p, l);
    end
    chk("sat_reach", Count, 255);
    st = up_of(st); apply(st[1], st[0], 10, p, l);
    chk("sat_pulses", p, 1); chk("sat_count", Count, 255); chk("sat_dir", Direction, 1);

    Enable = 1'b0;
    st = down_of(st); apply(st[1], st[0], 10, p, l);
    chk("dis_pulses", p, 0); chk("dis_count", Count, 255); chk("dis_dir", Direction, 0);
    Enable = 1'b1;

    st = up_of(st); EncA = st[1]; EncB = st[0];
    repeat (5) @(negedge Clk);
    ClearCount = 1'b1; @(negedge Clk); ClearCount = 1'b0;
    chk("clrstep_sv", StepValid, 1); chk("clrstep_count", Count, 0); chk("clrstep_dir", Direction, 1);
    repeat (5) @(negedge Clk);

    st = up_of(st); apply(st[1], st[0], 10, p, l);
    chk("pre_rst_count", Count, 1);
    st = st ^ 2'b11; apply(st[1], st[0], 10, p, l);
    chk("pre_rst_err", Error, 1);
    st = up_of(st); EncA = st[1]; EncB = st[0];
    repeat (2) @(negedge Clk);
    #2 ResetN = 1'b0;
    #1;
    chk("async_count", Count, 0); chk("async_dir", Direction, 0);
    chk("async_sv", StepValid, 0); chk("async_err", Error, 0);
    EncA = 1'b1; EncB = 1'b1;
    @(negedge Clk); ResetN = 1'b1;
    apply(1, 1, 14, p, l);
    chk("prime11_pulses", p, 0); chk("prime11_err", Error, 0); chk("prime11_count", Count, 0);
    apply(1, 0, 10, p, l);
    chk("post11_pulses", p, 1); chk("post11_count", Count, 1); chk("post11_dir", Direction, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
